// File: rtl/player_life_ctrl.sv
// Purpose: player life/hit FSM (IDLE/PLAY/BLINK/OVER) with post-hit blink invulnerability window.
// Latency: every output is registered and reflects the state/counters one clock after the inputs are sampled.
// Backpressure: none; startGame/hitIn are level-sampled every cycle and never stalled.
module player_life_ctrl #(
   parameter int INIT_LIVES  = 3,
   parameter int BLINK_TICKS = 8,
   parameter int TICK_DIV    = 3125000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startGame,
   input  logic       hitIn,
   output logic       playGame,
   output logic       playerHit,
   output logic       hidePlayer,
   output logic       invulnerable,
   output logic [1:0] lives,
   output logic       gameOver
);

   // Prescaler width: enough to hold TICK_DIV-1 (TICK_DIV >= 2 keeps this >= 1).
   localparam int              TW         = $clog2(TICK_DIV);
   localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [1:0]      LIVES_INIT = 2'(INIT_LIVES);
   localparam logic [7:0]      BLINK_LOAD = 8'(BLINK_TICKS);

   // Out-of-range parameters would silently truncate the counters above.
   if (INIT_LIVES < 1 || INIT_LIVES > 3) begin : g_bad_lives
      $error("player_life_ctrl: INIT_LIVES must be 1..3");
   end
   if (BLINK_TICKS < 1 || BLINK_TICKS > 255) begin : g_bad_blink
      $error("player_life_ctrl: BLINK_TICKS must be 1..255");
   end
   if (TICK_DIV < 2 || TICK_DIV > 16777216) begin : g_bad_div
      $error("player_life_ctrl: TICK_DIV must be 2..2^24");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      BLINK = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    blinkCnt;
   logic [7:0]    blinkCnt_nxt;
   logic [TW-1:0] tickCnt;
   logic [TW-1:0] tickCnt_nxt;
   logic [1:0]    lives_nxt;
   logic          hit_nxt;
   logic          playGame_nxt;
   logic          gameOver_nxt;
   logic          invulnerable_nxt;
   logic          hidePlayer_nxt;

   // Next-state and counter update: hits only count in PLAY, restarts only in IDLE/OVER,
   // and the prescaler only runs in BLINK (it is parked at 0 everywhere else).
   always_comb begin
      state_nxt    = state;
      lives_nxt    = lives;
      blinkCnt_nxt = blinkCnt;
      tickCnt_nxt  = '0;
      hit_nxt      = 1'b0;
      case (state)
         IDLE, OVER: begin
            if (startGame) begin
               state_nxt    = PLAY;
               lives_nxt    = LIVES_INIT;
               blinkCnt_nxt = 8'd0;
            end
         end
         PLAY: begin
            // A simultaneous startGame is deliberately not looked at here.
            if (hitIn) begin
               hit_nxt = 1'b1;
               if (lives > 2'd1) begin
                  lives_nxt    = lives - 2'd1;
                  blinkCnt_nxt = BLINK_LOAD;
                  state_nxt    = BLINK;
               end else begin
                  lives_nxt = 2'd0;
                  state_nxt = OVER;
               end
            end
         end
         BLINK: begin
            if (tickCnt == TICK_LAST) begin
               tickCnt_nxt = '0;
               if (blinkCnt <= 8'd1) begin
                  blinkCnt_nxt = 8'd0;
                  state_nxt    = PLAY;
               end else begin
                  blinkCnt_nxt = blinkCnt - 8'd1;
               end
            end else begin
               tickCnt_nxt = tickCnt + 1'b1;
            end
         end
         default: begin
            state_nxt    = IDLE;
            lives_nxt    = 2'd0;
            blinkCnt_nxt = 8'd0;
         end
      endcase
   end

   // Output decode from the upcoming state so the registered outputs line up with it.
   always_comb begin
      playGame_nxt     = 1'b0;
      gameOver_nxt     = 1'b0;
      invulnerable_nxt = 1'b0;
      hidePlayer_nxt   = 1'b0;
      case (state_nxt)
         PLAY: begin
            playGame_nxt = 1'b1;
         end
         BLINK: begin
            playGame_nxt     = 1'b1;
            invulnerable_nxt = 1'b1;
            hidePlayer_nxt   = blinkCnt_nxt[0];
         end
         OVER: begin
            gameOver_nxt = 1'b1;
         end
         default: begin
            playGame_nxt = 1'b0;
         end
      endcase
   end

   // State, counters and all outputs; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         lives        <= 2'd0;
         blinkCnt     <= 8'd0;
         tickCnt      <= '0;
         playGame     <= 1'b0;
         playerHit    <= 1'b0;
         hidePlayer   <= 1'b0;
         invulnerable <= 1'b0;
         gameOver     <= 1'b0;
      end else begin
         state        <= state_nxt;
         lives        <= lives_nxt;
         blinkCnt     <= blinkCnt_nxt;
         tickCnt      <= tickCnt_nxt;
         playGame     <= playGame_nxt;
         playerHit    <= hit_nxt;
         hidePlayer   <= hidePlayer_nxt;
         invulnerable <= invulnerable_nxt;
         gameOver     <= gameOver_nxt;
      end
   end

endmodule

// File: tb/tb_player_life_ctrl.sv
// Bench for player_life_ctrl: directed game scenarios, a cycle-level game model, literal spot checks.
// Latency: outputs compared at every falling edge, one rising edge after inputs are applied.
// Backpressure: not applicable; inputs are driven freely each cycle.
module tb_player_life_ctrl;

   localparam int TD = 4;
   localparam int BT = 4;
   localparam int IL = 3;

   logic       clk;
   logic       reset;
   logic       startGame;
   logic       hitIn;
   logic       playGame;
   logic       playerHit;
   logic       hidePlayer;
   logic       invulnerable;
   logic [1:0] lives;
   logic       gameOver;

   int tests;
   int fails;

   // Game model: plain flags, a life count and the number of invulnerable cycles left.
   int m_active;
   int m_over;
   int m_lives;
   int m_hit;
   int m_inv_left;

   player_life_ctrl #(
      .INIT_LIVES (IL),
      .BLINK_TICKS(BT),
      .TICK_DIV   (TD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .startGame   (startGame),
      .hitIn       (hitIn),
      .playGame    (playGame),
      .playerHit   (playerHit),
      .hidePlayer  (hidePlayer),
      .invulnerable(invulnerable),
      .lives       (lives),
      .gameOver    (gameOver)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Blink phase: number of ticks still to come (rounded up) decides visibility.
   function automatic int exp_hide(input int inv_left);
      int ticks_left;
      if (inv_left <= 0) return 0;
      ticks_left = (inv_left + TD - 1) / TD;
      return ticks_left % 2;
   endfunction

   // Model update on every rising clock edge or reset assertion.
   initial begin
      m_active = 0; m_over = 0; m_lives = 0; m_hit = 0; m_inv_left = 0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_active = 0; m_over = 0; m_lives = 0; m_hit = 0; m_inv_left = 0;
         end else begin
            m_hit = 0;
            if (m_inv_left > 0) begin
               m_inv_left = m_inv_left - 1;
            end else if (m_active != 0) begin
               if (hitIn) begin
                  m_hit   = 1;
                  m_lives = m_lives - 1;
                  if (m_lives == 0) begin
                     m_active = 0;
                     m_over   = 1;
                  end else begin
                     m_inv_left = BT * TD;
                  end
               end
            end else if (startGame) begin
               m_active = 1;
               m_over   = 0;
               m_lives  = IL;
            end
         end
      end
   end

   // Compare every output against the model on each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("m_playGame",     playGame,     m_active);
         chk("m_gameOver",     gameOver,     m_over);
         chk("m_lives",        lives,        m_lives);
         chk("m_playerHit",    playerHit,    m_hit);
         chk("m_invulnerable", invulnerable, (m_inv_left > 0) ? 1 : 0);
         chk("m_hidePlayer",   hidePlayer,   exp_hide(m_inv_left));
      end
   end

   task automatic drive(input logic s, input logic h);
      @(posedge clk);
      #2;
      startGame = s;
      hitIn     = h;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0);
   endtask

   task automatic restart();
      @(posedge clk);
      #2;
      reset = 1'b1; startGame = 1'b0; hitIn = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
   endtask

   logic [15:0] hide_pat;

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      startGame = 1'b0;
      hitIn = 1'b0;
      hide_pat = 16'b1111_0000_1111_0000;

      // Reset state.
      repeat (2) @(posedge clk);
      #3;
      chk("rst_playGame", playGame, 0);
      chk("rst_lives", lives, 0);
      chk("rst_gameOver", gameOver, 0);
      chk("rst_invulnerable", invulnerable, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Hits before a game starts are ignored.
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("idle_hit_lives", lives, 0);
      chk("idle_hit_pulse", playerHit, 0);

      // Start.
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("start_playGame", playGame, 1);
      chk("start_lives", lives, 3);
      chk("start_gameOver", gameOver, 0);

      // Single hit and the 16-cycle blink window.
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("hit_pulse", playerHit, 1);
      chk("hit_lives", lives, 2);
      chk("hit_invulnerable", invulnerable, 1);
      chk("hit_hide0", hidePlayer, 0);
      for (int k = 1; k < 16; k++) begin
         drive(1'b0, 1'b0);
         @(negedge clk);
         chk("blink_hide", hidePlayer, int'(hide_pat[k]));
         chk("blink_inv", invulnerable, 1);
         chk("blink_pulse", playerHit, 0);
      end
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("blink_end_inv", invulnerable, 0);
      chk("blink_end_hide", hidePlayer, 0);
      chk("blink_end_play", playGame, 1);

      // Hit held high across the whole window.
      restart();
      drive(1'b0, 1'b1);
      for (int k = 0; k < 18; k++) begin
         drive(1'b0, 1'b1);
         @(negedge clk);
         if (k == 0)  chk("held_first_lives", lives, 2);
         if (k == 8)  chk("held_mid_lives", lives, 2);
         if (k == 16) chk("held_exit_inv", invulnerable, 0);
         if (k == 17) begin
            chk("held_second_lives", lives, 1);
            chk("held_second_pulse", playerHit, 1);
         end
      end
      drive(1'b0, 1'b0);
      idle(20);

      // Last life: game over, hits then ignored, restart.
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("over_lives", lives, 0);
      chk("over_flag", gameOver, 1);
      chk("over_playGame", playGame, 0);
      chk("over_pulse", playerHit, 1);
      repeat (4) drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("over_hit_lives", lives, 0);
      chk("over_hit_pulse", playerHit, 0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("replay_lives", lives, 3);
      chk("replay_playGame", playGame, 1);
      chk("replay_gameOver", gameOver, 0);

      // Start and hit together: hit only.
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("both_lives", lives, 2);
      chk("both_inv", invulnerable, 1);
      chk("both_pulse", playerHit, 1);

      // Reset between edges in mid-blink.
      idle(5);
      #4;
      reset = 1'b1;
      #1;
      chk("async_playGame", playGame, 0);
      chk("async_lives", lives, 0);
      chk("async_inv", invulnerable, 0);
      chk("async_hide", hidePlayer, 0);
      chk("async_pulse", playerHit, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (4) drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_playGame", playGame, 0);
      chk("post_rst_lives", lives, 0);
      chk("post_rst_pulse", playerHit, 0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_start_lives", lives, 3);

      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
